// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared types for the AES-256 decryption datapath
package aes_dec_pkg;

  localparam int AES_NB     = 4;
  localparam int AES_BYTE_W = 8;

  typedef logic [AES_NB-1:0][AES_BYTE_W-1:0] aes_row_t;

  typedef enum logic [1:0] {S_ROW0, S_ROW1, S_ROW2, S_ROW3} shrow_state_t;

endpackage

// File: rtl/mod_dec_inv_shifter_if.sv
// rtl/mod_dec_inv_shifter_if.sv - row stream in/out bundle for the InvShiftRows stage
interface mod_dec_inv_shifter_if;
  import aes_dec_pkg::*;

  logic     wr_en;
  logic     in_ready;
  aes_row_t inp;
  aes_row_t outp;
  logic     out_valid;
  logic     out_ready;
  logic [1:0] row_idx;
  logic     done;

  modport master (
    output wr_en, inp, out_ready,
    input  in_ready, outp, out_valid, row_idx, done
  );

  modport slave (
    input  wr_en, inp, out_ready,
    output in_ready, outp, out_valid, row_idx, done
  );

endinterface

// File: rtl/mod_dec_rot_row.sv
// rtl/mod_dec_rot_row.sv - combinational byte right-rotator for one state row
module mod_dec_rot_row
  import aes_dec_pkg::*;
(
  input  aes_row_t   row_i,
  input  logic [1:0] amt,
  output aes_row_t   row_o
);

  logic [1:0] sel;

  // Column c takes byte (c - amt) mod 4; 2-bit wrap does the modulo.
  always_comb begin
    row_o = '0;
    sel   = '0;
    for (int c = 0; c < AES_NB; c++) begin
      sel      = 2'(c) - amt;
      row_o[c] = row_i[sel];
    end
  end

endmodule

// File: rtl/mod_dec_inv_shifter.sv
// rtl/mod_dec_inv_shifter.sv - InvShiftRows stage: rotates each row right by its row index
module mod_dec_inv_shifter
  import aes_dec_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic resetn,
  input logic clr,
  mod_dec_inv_shifter_if.slave bus
);

  if (N != AES_NB || W != AES_BYTE_W) begin : g_bad_param
    $error("mod_dec_inv_shifter supports only N=4, W=8");
  end

  shrow_state_t state_q, state_d;
  logic         accept;
  logic         in_ready;
  logic         out_valid_q;
  logic         done_q;
  logic [1:0]   row_idx_q;
  aes_row_t     outp_q;
  aes_row_t     rot_row;

  mod_dec_rot_row u_rot (
    .row_i (bus.inp),
    .amt   (state_q),
    .row_o (rot_row)
  );

  always_ff @(posedge clk) begin
    if (!resetn || clr) state_q <= S_ROW0;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_ROW0:  state_d = S_ROW1;
        S_ROW1:  state_d = S_ROW2;
        S_ROW2:  state_d = S_ROW3;
        default: state_d = S_ROW0;
      endcase
    end
  end

  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    accept   = bus.wr_en && in_ready;
  end

  // A new accept overrides a concurrent drain, so a full pipe streams without bubbles.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      outp_q      <= '0;
      out_valid_q <= 1'b0;
      row_idx_q   <= 2'd0;
      done_q      <= 1'b0;
    end else if (accept) begin
      outp_q      <= rot_row;
      out_valid_q <= 1'b1;
      row_idx_q   <= state_q;
      done_q      <= (state_q == S_ROW3);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.outp      = outp_q;
  assign bus.out_valid = out_valid_q;
  assign bus.row_idx   = row_idx_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mod_dec_inv_shifter.sv
// tb/tb_mod_dec_inv_shifter.sv - directed self-checking bench for mod_dec_inv_shifter
module tb_mod_dec_inv_shifter;
  import aes_dec_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  mod_dec_inv_shifter_if bus ();

  mod_dec_inv_shifter #(.N(4), .W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic aes_row_t mk(input logic [7:0] b0, b1, b2, b3);
    aes_row_t r;
    r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input aes_row_t row, input int idx, input logic dn);
    check({tag, "_outp"}, bus.outp, row);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_idx"}, 32'(bus.row_idx), 32'(idx));
    check({tag, "_done"}, 32'(bus.done), 32'(dn));
  endtask

  task automatic do_clr();
    clr = 1'b1; bus.wr_en = 1'b0;
    step();
    clr = 1'b0;
  endtask

  aes_row_t exp_full [4];

  initial begin
    resetn = 1'b0; clr = 1'b0;
    bus.wr_en = 1'b1; bus.out_ready = 1'b1;
    bus.inp = aes_row_t'($urandom);

    // Reset with traffic present
    step(); step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_outp", bus.outp, 32'd0);
    check("rst_idx", 32'(bus.row_idx), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    resetn = 1'b1;
    bus.wr_en = 1'b0;
    step();

    // Full state, streaming
    exp_full[0] = mk(8'h00, 8'h01, 8'h02, 8'h03);
    exp_full[1] = mk(8'h03, 8'h00, 8'h01, 8'h02);
    exp_full[2] = mk(8'h02, 8'h03, 8'h00, 8'h01);
    exp_full[3] = mk(8'h01, 8'h02, 8'h03, 8'h00);
    bus.inp = mk(8'h00, 8'h01, 8'h02, 8'h03);
    bus.wr_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      step();
      check_out($sformatf("full_r%0d", r), exp_full[r], r, r == 3);
    end
    bus.wr_en = 1'b0;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_done", 32'(bus.done), 32'd0);
    check("drain_outp_kept", bus.outp, exp_full[3]);

    // Backpressure
    bus.inp = mk(8'h10, 8'h11, 8'h12, 8'h13);
    bus.wr_en = 1'b1;
    step();
    check_out("bp_r0", mk(8'h10, 8'h11, 8'h12, 8'h13), 0, 1'b0);
    bus.out_ready = 1'b0;
    bus.inp = mk(8'h20, 8'h21, 8'h22, 8'h23);
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("bp_hold%0d", i), mk(8'h10, 8'h11, 8'h12, 8'h13), 0, 1'b0);
      check($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check_out("bp_r1", mk(8'h23, 8'h20, 8'h21, 8'h22), 1, 1'b0);
    bus.wr_en = 1'b0;
    step();

    // Wrap-around
    do_clr();
    check("clr_valid", 32'(bus.out_valid), 32'd0);
    bus.inp = mk(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    bus.wr_en = 1'b1;
    step(); step(); step(); step();
    check_out("wrap_r3", mk(8'hBB, 8'hCC, 8'hDD, 8'hAA), 3, 1'b1);
    step();
    check_out("wrap_r0", mk(8'hAA, 8'hBB, 8'hCC, 8'hDD), 0, 1'b0);
    bus.wr_en = 1'b0;
    step();

    // Abort mid-state
    do_clr();
    bus.inp = mk(8'h30, 8'h31, 8'h32, 8'h33);
    bus.wr_en = 1'b1;
    step(); step();
    check_out("abort_r1", mk(8'h33, 8'h30, 8'h31, 8'h32), 1, 1'b0);
    clr = 1'b1;
    bus.inp = mk(8'h00, 8'h01, 8'h02, 8'h03);
    step();
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_outp", bus.outp, 32'd0);
    clr = 1'b0;
    bus.inp = mk(8'h40, 8'h41, 8'h42, 8'h43);
    step();
    check_out("abort_next", mk(8'h40, 8'h41, 8'h42, 8'h43), 0, 1'b0);
    bus.wr_en = 1'b0;
    step();

    // Reset mid-state
    do_clr();
    bus.inp = mk(8'h60, 8'h61, 8'h62, 8'h63);
    bus.wr_en = 1'b1;
    step(); step(); step();
    check_out("mrst_r2", mk(8'h62, 8'h63, 8'h60, 8'h61), 2, 1'b0);
    bus.wr_en = 1'b0; bus.out_ready = 1'b0;
    resetn = 1'b0;
    step();
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_outp", bus.outp, 32'd0);
    check("mrst_idx", 32'(bus.row_idx), 32'd0);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    bus.inp = mk(8'h50, 8'h51, 8'h52, 8'h53);
    bus.wr_en = 1'b1;
    step();
    check_out("mrst_next", mk(8'h50, 8'h51, 8'h52, 8'h53), 0, 1'b0);
    bus.wr_en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_dec_inv_shifter.md
Name: mod_dec_inv_shifter

Overview:
- Decryption-side InvShiftRows stage for the AES-256 core. It is the inverse of the encryption shifter.
- Accepts one 4-byte state row per transfer, in row order 0..3, and right-rotates each row by its row index.
- Output is registered and held under backpressure. `done` flags the last row of each state.
- Sits between InvSubBytes/AddRoundKey row traffic in the decryption round datapath.

Parameters:
- N, 4: bytes per row and number of rows per state. Only 4 is supported; any other value triggers an elaboration $error.
- W, 8: bits per byte.

Ports:
- clk  input  1  core clock; all logic is rising-edge.
- resetn  input  1  synchronous, active-low reset.
- clr  input  1  synchronous abort: drops the held row and returns the row counter to 0.
- wr_en  input  1  input row valid.
- in_ready  output  1  stage can accept a row this cycle.
- inp  input  [N-1:0][W-1:0]  input row; inp[c] is column c.
- outp  output  [N-1:0][W-1:0]  rotated row.
- out_valid  output  1  outp holds a valid row.
- out_ready  input  1  downstream accepts outp this cycle.
- row_idx  output  2  row index of the row currently in outp.
- done  output  1  high while outp holds row 3 of a state.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, resetn).
- Reset values (resetn=0 at a rising edge): outp=0, out_valid=0, row_idx=0, done=0, row state=S_ROW0.
- Priority at each edge: resetn, then clr, then normal operation.
- clr=1: same effect as reset on all state and outputs. A wr_en in that cycle is discarded.
- Row-state FSM: S_ROW0 -> S_ROW1 -> S_ROW2 -> S_ROW3 -> S_ROW0.
  - Advances only on an accept.
  - The state number is the row index applied to the accepted row.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = wr_en && in_ready.
  - Output handshake = out_valid && out_ready.
- On accept with current state r:
  - outp[c] <= inp[(c - r) mod 4] for c = 0..3.
  - row_idx <= r; out_valid <= 1; done <= (r == 3).
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 row/cycle while out_ready=1.
- Simultaneous output handshake and accept in the same cycle: the new row replaces the old one. out_valid stays 1; no bubble, no loss.
- Output handshake with no accept: out_valid <= 0, done <= 0. outp and row_idx keep their last values.
- Hold rule: while out_valid && !out_ready, outp, row_idx and done are stable. Stall-cycle inputs are not accepted and do not advance the FSM.
- wr_en while in_ready=0: ignored; the producer must hold the row.
- Wrap-around: after row 3 is accepted, the next accepted row is treated as row 0 of the next state.
- No state or counter ever changes on a cycle without an accept, clr or reset.
- Arithmetic: byte selection index is (c - r) mod 4 on 2-bit unsigned values. Bytes pass unmodified; no arithmetic on data.

Decomposition:
- Package aes_dec_pkg:
  - AES_NB = 4, AES_BYTE_W = 8.
  - typedef logic [AES_NB-1:0][AES_BYTE_W-1:0] aes_row_t.
  - typedef enum logic [1:0] {S_ROW0, S_ROW1, S_ROW2, S_ROW3} shrow_state_t.
  - The encryption shifter should migrate to aes_row_t.
- Sub-module mod_dec_rot_row:
  - Purely combinational right-rotator: inputs row and 2-bit amount, output rotated row.
  - Reusable by the key-schedule RotWord logic.
- mod_dec_inv_shifter instantiates one mod_dec_rot_row plus the FSM and output register.

Test Plan:
1. Reset: hold resetn=0 for 2 edges with wr_en=1 and inp random -> out_valid=0, outp=0, row_idx=0, done=0, in_ready=1.
2. Full state, out_ready=1: inp = {00,01,02,03} (inp[0]=00), wr_en=1 for 4 consecutive cycles. Required outp[0..3] per row:
   - row0 = 00 01 02 03
   - row1 = 03 00 01 02
   - row2 = 02 03 00 01
   - row3 = 01 02 03 00
   - Each row appears one cycle after its accept; row_idx = 0, 1, 2, 3; done=1 only with row3.
3. Backpressure: accept row0 = {10,11,12,13}, then out_ready=0 for 3 cycles while wr_en=1 with {20,21,22,23}:
   - During the stall: outp stays 10 11 12 13, in_ready=0, FSM stays S_ROW1.
   - After out_ready=1: the next row out is 23 20 21 22 with row_idx=1.
4. Wrap: send 5 rows of {AA,BB,CC,DD} -> fifth output is AA BB CC DD with row_idx=0, done=0.
5. Abort: accept rows 0 and 1, then assert clr together with wr_en {00,01,02,03} -> next edge has out_valid=0 and that row dropped. The next accepted row uses rotation 0.
6. Reset mid-state: after row 2 is accepted with out_ready=0, pulse resetn=0 for one edge -> outputs return to reset values. The next accepted row uses rotation 0.
